id_stage_piped: RTL and testbench

Parametrised instruction-decode stage for the ARM-subset pipeline. It combines the register file, a write-through bypass, a condition check, a hazard unit and the ID/EXE pipeline register in one block. It sits between the IF/ID register and the EXE stage. The external control unit still supplies the decoded control bundle. Unlike the previous ID stage, it registers its own outputs, supports stall/flush/bubble insertion, has a configurable register count and data width, and has a forwarding-aware hazard mode and a stall counter.

---
 rtl/id_stage_piped.sv | 191 +++++++++++++++++++
 tb/tb_id_stage_piped.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_piped.sv
// Instruction-decode stage: register file with write-through, ARM condition check,
// RAW hazard detection and the ID/EXE pipeline register with bubble/flush and stall counter.
module id_stage_piped #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 15,
   parameter int REG_AW   = 4,
   parameter int FWD_EN   = 0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr_in,
   input  logic              instr_valid,
   input  logic [8:0]        ctrl_in,
   input  logic              one_src_in,
   input  logic [3:0]        status_regs,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              exe_wb_en,
   input  logic              exe_mem_read,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic              mem_wb_en,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              flush,
   output logic              stall,
   output logic              id_valid,
   output logic [8:0]        id_ctrl,
   output logic [DATA_W-1:0] id_val_rn,
   output logic [DATA_W-1:0] id_val_rm,
   output logic              id_imm,
   output logic [11:0]       id_shift_operand,
   output logic [23:0]       id_signed_imm,
   output logic [REG_AW-1:0] id_dest,
   output logic [REG_AW-1:0] id_src1,
   output logic [REG_AW-1:0] id_src2,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [REG_AW:0] NREGS_W = (REG_AW+1)'(NUM_REGS);
   localparam bit              FWD     = (FWD_EN != 0);

   logic [DATA_W-1:0] rf_q [NUM_REGS];

   logic              mem_write_s, two_src_s, cond_pass_s, hazard_s, stall_s;
   logic              exe_prod_s, mem_prod_s;
   logic [REG_AW-1:0] src1_s, src2_s;
   logic [DATA_W-1:0] val_rn_s, val_rm_s;

   logic              valid_q, valid_d, imm_q, imm_d;
   logic [8:0]        ctrl_q, ctrl_d;
   logic [DATA_W-1:0] rn_q, rn_d, rm_q, rm_d;
   logic [11:0]       shift_q, shift_d;
   logic [23:0]       simm_q, simm_d;
   logic [REG_AW-1:0] dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   function automatic logic in_range(input logic [REG_AW-1:0] idx);
      return ({1'b0, idx} < NREGS_W);
   endfunction

   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         4'b0000: return z;
         4'b0001: return ~z;
         4'b0010: return c;
         4'b0011: return ~c;
         4'b0100: return n;
         4'b0101: return ~n;
         4'b0110: return v;
         4'b0111: return ~v;
         4'b1000: return c & ~z;
         4'b1001: return ~c | z;
         4'b1010: return (n == v);
         4'b1011: return (n != v);
         4'b1100: return ~z & (n == v);
         4'b1101: return z | (n != v);
         4'b1110: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Out-of-range indices read as zero, even when the write port targets them.
   function automatic logic [DATA_W-1:0] rf_read(input logic [REG_AW-1:0] idx);
      if (!in_range(idx)) return '0;
      else if (wb_en && (wb_dest == idx)) return wb_data;
      else return rf_q[idx];
   endfunction

   assign mem_write_s = ctrl_in[3];
   assign src1_s      = REG_AW'(instr_in[19:16]);
   assign src2_s      = mem_write_s ? REG_AW'(instr_in[15:12]) : REG_AW'(instr_in[3:0]);
   assign two_src_s   = ~instr_in[25] | mem_write_s;
   assign cond_pass_s = cond_ok(instr_in[31:28], status_regs);
   assign val_rn_s    = rf_read(src1_s);
   assign val_rm_s    = rf_read(src2_s);

   // With forwarding downstream only a load in EXE cannot be bypassed in time.
   assign exe_prod_s = FWD ? (exe_wb_en & exe_mem_read) : exe_wb_en;
   assign mem_prod_s = FWD ? 1'b0 : mem_wb_en;
   assign hazard_s   = (exe_prod_s & ((~one_src_in & (src1_s == exe_dest)) |
                                      (two_src_s   & (src2_s == exe_dest)))) |
                       (mem_prod_s & ((~one_src_in & (src1_s == mem_dest)) |
                                      (two_src_s   & (src2_s == mem_dest))));
   assign stall_s    = instr_valid & hazard_s & ~flush;
   assign stall      = stall_s;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else if (wb_en && in_range(wb_dest)) begin
         rf_q[wb_dest] <= wb_data;
      end
   end

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      rn_d    = rn_q;
      rm_d    = rm_q;
      imm_d   = imm_q;
      shift_d = shift_q;
      simm_d  = simm_q;
      dest_d  = dest_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      cnt_d   = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = 9'd0;
      end else if (stall_s) begin
         valid_d = 1'b0;
         ctrl_d  = 9'd0;
         cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
         valid_d = instr_valid & cond_pass_s;
         ctrl_d  = (instr_valid & cond_pass_s) ? ctrl_in : 9'd0;
         rn_d    = val_rn_s;
         rm_d    = val_rm_s;
         imm_d   = instr_in[25];
         shift_d = instr_in[11:0];
         simm_d  = instr_in[23:0];
         dest_d  = REG_AW'(instr_in[15:12]);
         src1_d  = src1_s;
         src2_d  = src2_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= 9'd0;
         rn_q    <= '0;
         rm_q    <= '0;
         imm_q   <= 1'b0;
         shift_q <= 12'd0;
         simm_q  <= 24'd0;
         dest_q  <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         rn_q    <= rn_d;
         rm_q    <= rm_d;
         imm_q   <= imm_d;
         shift_q <= shift_d;
         simm_q  <= simm_d;
         dest_q  <= dest_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign id_valid         = valid_q;
   assign id_ctrl          = ctrl_q;
   assign id_val_rn        = rn_q;
   assign id_val_rm        = rm_q;
   assign id_imm           = imm_q;
   assign id_shift_operand = shift_q;
   assign id_signed_imm    = simm_q;
   assign id_dest          = dest_q;
   assign id_src1          = src1_q;
   assign id_src2          = src2_q;
   assign stall_cnt        = cnt_q;

endmodule

// File: tb/tb_id_stage_piped.sv
// Directed bench: one default instance (no forwarding) and one with FWD_EN=1, CNT_W=2,
// both driven from the same inputs and checked against hand-computed values.
module tb_id_stage_piped;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic [8:0]  ctrl_in;
   logic        one_src_in;
   logic [3:0]  status_regs;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_data;
   logic        exe_wb_en, exe_mem_read, mem_wb_en, flush;
   logic [3:0]  exe_dest, mem_dest;

   logic        a_stall, a_valid, a_imm;
   logic [8:0]  a_ctrl;
   logic [31:0] a_rn, a_rm;
   logic [11:0] a_shift;
   logic [23:0] a_simm;
   logic [3:0]  a_dest, a_src1, a_src2;
   logic [15:0] a_cnt;

   logic        f_stall, f_valid, f_imm;
   logic [8:0]  f_ctrl;
   logic [31:0] f_rn, f_rm;
   logic [11:0] f_shift;
   logic [23:0] f_simm;
   logic [3:0]  f_dest, f_src1, f_src2;
   logic [1:0]  f_cnt;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   id_stage_piped dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
      .ctrl_in(ctrl_in), .one_src_in(one_src_in), .status_regs(status_regs),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
      .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .flush(flush),
      .stall(a_stall), .id_valid(a_valid), .id_ctrl(a_ctrl),
      .id_val_rn(a_rn), .id_val_rm(a_rm), .id_imm(a_imm),
      .id_shift_operand(a_shift), .id_signed_imm(a_simm),
      .id_dest(a_dest), .id_src1(a_src1), .id_src2(a_src2), .stall_cnt(a_cnt)
   );

   id_stage_piped #(.FWD_EN(1), .CNT_W(2)) dut_f (
      .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
      .ctrl_in(ctrl_in), .one_src_in(one_src_in), .status_regs(status_regs),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
      .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .flush(flush),
      .stall(f_stall), .id_valid(f_valid), .id_ctrl(f_ctrl),
      .id_val_rn(f_rn), .id_val_rm(f_rm), .id_imm(f_imm),
      .id_shift_operand(f_shift), .id_signed_imm(f_simm),
      .id_dest(f_dest), .id_src1(f_src1), .id_src2(f_src2), .stall_cnt(f_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; instr_in = 32'd0; instr_valid = 1'b0; ctrl_in = 9'd0;
      one_src_in = 1'b0; status_regs = 4'd0; wb_en = 1'b0; wb_dest = 4'd0;
      wb_data = 32'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_dest = 4'd0;
      mem_wb_en = 1'b0; mem_dest = 4'd0; flush = 1'b0;

      step(); step();
      chk("rst_valid", 64'(a_valid), 64'd0);
      chk("rst_ctrl",  64'(a_ctrl),  64'd0);
      chk("rst_rn",    64'(a_rn),    64'd0);
      chk("rst_dest",  64'(a_dest),  64'd0);
      chk("rst_cnt",   64'(a_cnt),   64'd0);

      // write R3, no live instruction yet
      rst = 1'b1; wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'hDEADBEEF;
      step();
      chk("pre_adv_valid", 64'(a_valid), 64'd0);
      chk("pre_adv_rn",    64'(a_rn),    64'd0);

      // ADD R1,R3,#5
      wb_en = 1'b0; instr_in = 32'hE2831005; instr_valid = 1'b1;
      ctrl_in = 9'h044; one_src_in = 1'b1;
      step();
      chk("add_rn",    64'(a_rn),    64'hDEADBEEF);
      chk("add_valid", 64'(a_valid), 64'd1);
      chk("add_ctrl",  64'(a_ctrl),  64'h044);
      chk("add_imm",   64'(a_imm),   64'd1);
      chk("add_shift", 64'(a_shift), 64'h005);
      chk("add_simm",  64'(a_simm),  64'h831005);
      chk("add_dest",  64'(a_dest),  64'd1);
      chk("add_src2",  64'(a_src2),  64'd5);
      chk("add_f_rn",  64'(f_rn),    64'hDEADBEEF);

      // write-through: ADD R2,R5,#0 while R5 is being written
      wb_en = 1'b1; wb_dest = 4'd5; wb_data = 32'h00001234; instr_in = 32'hE2852000;
      step();
      chk("wt_rn",   64'(a_rn),   64'h1234);
      chk("wt_dest", 64'(a_dest), 64'd2);

      // EQ with Z=0 fails
      wb_en = 1'b0; instr_in = 32'h02857000; status_regs = 4'b0000;
      step();
      chk("eq_fail_valid", 64'(a_valid), 64'd0);
      chk("eq_fail_ctrl",  64'(a_ctrl),  64'd0);
      chk("eq_fail_dest",  64'(a_dest),  64'd7);
      chk("eq_fail_rn",    64'(a_rn),    64'h1234);

      status_regs = 4'b0100;
      step();
      chk("eq_pass_valid", 64'(a_valid), 64'd1);
      chk("eq_pass_ctrl",  64'(a_ctrl),  64'h044);

      // GT with N!=V fails
      instr_in = 32'hC2857000; status_regs = 4'b1000;
      step();
      chk("gt_fail_valid", 64'(a_valid), 64'd0);

      // GE with N==V passes
      instr_in = 32'hA2857000; status_regs = 4'b1001;
      step();
      chk("ge_pass_valid", 64'(a_valid), 64'd1);

      // cond 1111 never executes
      instr_in = 32'hF2857000; status_regs = 4'b0100;
      step();
      chk("nv_valid", 64'(a_valid), 64'd0);

      // ADD R4,R1,R2 (register form), EXE writes R2, not a load
      instr_in = 32'hE0814002; one_src_in = 1'b0; status_regs = 4'b0000;
      exe_wb_en = 1'b1; exe_dest = 4'd2; exe_mem_read = 1'b0;
      #1;
      chk("raw_stall",     64'(a_stall), 64'd1);
      chk("fwd_alu_stall", 64'(f_stall), 64'd0);
      step();
      chk("raw_bubble_valid", 64'(a_valid), 64'd0);
      chk("raw_bubble_ctrl",  64'(a_ctrl),  64'd0);
      chk("raw_cnt",          64'(a_cnt),   64'd1);
      chk("fwd_alu_valid",    64'(f_valid), 64'd1);
      chk("fwd_alu_cnt",      64'(f_cnt),   64'd0);

      exe_mem_read = 1'b1;
      #1;
      chk("fwd_load_stall", 64'(f_stall), 64'd1);
      step();
      chk("load_cnt_a", 64'(a_cnt), 64'd2);
      chk("load_cnt_f", 64'(f_cnt), 64'd1);

      // MEM producer of Rn: only the non-forwarding stage stalls
      exe_wb_en = 1'b0; exe_mem_read = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd1;
      #1;
      chk("mem_stall_a", 64'(a_stall), 64'd1);
      chk("mem_stall_f", 64'(f_stall), 64'd0);
      step();
      chk("mem_cnt_a",   64'(a_cnt),   64'd3);
      chk("mem_valid_f", 64'(f_valid), 64'd1);

      // flush beats the hazard
      exe_wb_en = 1'b1; exe_mem_read = 1'b1; flush = 1'b1;
      #1;
      chk("flush_stall_a", 64'(a_stall), 64'd0);
      chk("flush_stall_f", 64'(f_stall), 64'd0);
      step();
      chk("flush_valid_f", 64'(f_valid), 64'd0);
      chk("flush_ctrl_f",  64'(f_ctrl),  64'd0);
      chk("flush_cnt_a",   64'(a_cnt),   64'd3);
      chk("flush_cnt_f",   64'(f_cnt),   64'd1);

      // five stall cycles saturate the 2-bit counter
      flush = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("sat_cnt_f", 64'(f_cnt), 64'd3);
      chk("cnt_a_8",   64'(a_cnt), 64'd8);

      // STR R5,[R1]: second source is Rd
      exe_wb_en = 1'b0; exe_mem_read = 1'b0; mem_wb_en = 1'b0;
      instr_in = 32'hE5815000; ctrl_in = 9'h008;
      step();
      chk("str_src2", 64'(a_src2), 64'd5);
      chk("str_rm",   64'(a_rm),   64'h1234);

      // index 15 lies outside the register file: write ignored, read returns zero
      wb_en = 1'b1; wb_dest = 4'd15; wb_data = 32'hCAFEF00D; ctrl_in = 9'h044;
      step();
      wb_en = 1'b0; instr_in = 32'hE08F000F;
      step();
      chk("r15_rn",   64'(a_rn),   64'd0);
      chk("r15_rm",   64'(a_rm),   64'd0);
      chk("r15_src1", 64'(a_src1), 64'd15);

      // mid-run reset clears the register file
      rst = 1'b0;
      step();
      chk("mid_rst_valid", 64'(a_valid), 64'd0);
      chk("mid_rst_cnt",   64'(a_cnt),   64'd0);
      rst = 1'b1; instr_in = 32'hE2831005; one_src_in = 1'b1;
      step();
      chk("mid_rst_r3", 64'(a_rn),    64'd0);
      chk("mid_rst_v",  64'(a_valid), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
